// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter slice.
package i2c_arb_pkg;

  localparam int unsigned FRAME_W = 24;

  // Codec device addresses (8-bit write form as sent on the bus)
  localparam logic [7:0] ES8156_ADDR = 8'h12;
  localparam logic [7:0] ADC_ADDR    = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_WAIT_REL,
    ST_RESP
  } state_e;

  // Build a write frame {dev_addr, reg_addr, data}
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [7:0] dev,
                                                    input logic [7:0] reg_addr,
                                                    input logic [7:0] data);
    return {dev, reg_addr, data};
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Search upward from rr_ptr, wrapping at NUM_REQ; first hit wins
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin sharing of one I2C write engine with NACK retry and watchdog.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned TIMEOUT_CYC = 60000
) (
  input  logic                   clk_12M,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*24-1:0]  req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [23:0]            eng_data,
  input  logic                   eng_done,
  input  logic                   eng_nack
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 eng_start_q, eng_start_d;
  logic [FRAME_W-1:0]   eng_data_q, eng_data_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [2:0]           retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 nack_q, nack_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 tmo_hit;
  logic [CNT_W-1:0]     tmo_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign tmo_hit  = (tmo_cnt_q == CNT_LAST);
  assign tmo_next = tmo_hit ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  // Next-state, counters and response pulses
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    eng_start_d = eng_start_q;
    eng_data_d  = eng_data_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    retry_cnt_d = retry_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    nack_d      = nack_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        // The owner still holds req during its done/err cycle, so that
        // cycle is skipped to avoid re-granting from a stale level.
        if ((|req) && !(|done_q) && !(|err_q)) begin
          eng_data_d  = req_data[int'(pick_idx)*FRAME_W +: FRAME_W];
          gnt_d       = pick;
          owner_d     = pick_idx;
          retry_cnt_d = '0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        eng_start_d = 1'b1;
        tmo_cnt_d   = '0;
        nack_d      = 1'b0;
        tmo_d       = 1'b0;
        state_d     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmo_cnt_d = tmo_next;
        if (eng_done) begin
          eng_start_d = 1'b0;
          nack_d      = eng_nack;
          state_d     = ST_WAIT_REL;
        end else if (tmo_hit) begin
          eng_start_d = 1'b0;
          tmo_d       = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_WAIT_REL: begin
        tmo_cnt_d = tmo_next;
        if (!eng_done) begin
          if (nack_q && (retry_cnt_q < RETRY_MAX)) begin
            retry_cnt_d = retry_cnt_q + 3'd1;
            state_d     = ST_START;
          end else begin
            state_d = ST_RESP;
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tmo_q || nack_q) begin
          err_d[owner_q] = 1'b1;
        end else begin
          done_d[owner_q] = 1'b1;
        end
        gnt_d    = '0;
        rr_ptr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_12M) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      retry_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      nack_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      retry_cnt_q <= retry_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      nack_q      <= nack_d;
      tmo_q       <= tmo_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: main instance plus a short-timeout instance.
module tb_i2c_cmd_arbiter;

  logic        clk_12M = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, done, err;
  logic [47:0] req_data;
  logic        busy, eng_start, eng_done, eng_nack;
  logic [23:0] eng_data;

  logic [1:0]  t_req, t_gnt, t_done, t_err;
  logic [47:0] t_req_data;
  logic        t_busy, t_eng_start, t_eng_done, t_eng_nack;
  logic [23:0] t_eng_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_12M = ~clk_12M;

  i2c_cmd_arbiter #(.NUM_REQ(2), .MAX_RETRY(2), .TIMEOUT_CYC(60000)) dut (
    .clk_12M(clk_12M), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_nack(eng_nack)
  );

  i2c_cmd_arbiter #(.NUM_REQ(2), .MAX_RETRY(2), .TIMEOUT_CYC(100)) dut_to (
    .clk_12M(clk_12M), .rst(rst), .req(t_req), .req_data(t_req_data),
    .gnt(t_gnt), .done(t_done), .err(t_err), .busy(t_busy),
    .eng_start(t_eng_start), .eng_data(t_eng_data),
    .eng_done(t_eng_done), .eng_nack(t_eng_nack)
  );

  task automatic step();
    @(posedge clk_12M);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; eng_done = 1'b0; eng_nack = 1'b0;
    t_req = '0; t_req_data = '0; t_eng_done = 1'b0; t_eng_nack = 1'b0;
    step(); step();
    rst = 1'b0;
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start: got %b expected 0", eng_start); end
    n_chk++; if (eng_data !== 24'h0) begin n_fail++; $display("FAIL reset_eng_data: got %h expected 000000", eng_data); end
    n_chk++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL reset_t_busy: got %b expected 0", t_busy); end
  endtask

  task automatic test_single();
    step();
    req_data[23:0] = 24'h120205; req = 2'b01;
    step();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b expected 01", gnt); end
    n_chk++; if (eng_data !== 24'h120205) begin n_fail++; $display("FAIL single_data: got %h expected 120205", eng_data); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b expected 0", eng_start); end
    step();
    n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", eng_start); end
    repeat (199) step();
    n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL single_start_held: got %b expected 1", eng_start); end
    eng_done = 1'b1; eng_nack = 1'b0;
    step();
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b expected 0", eng_start); end
    eng_done = 1'b0;
    step();
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL single_done_early: got %b expected 00", done); end
    step();
    n_chk++; if (done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b expected 01", done); end
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL single_err: got %b expected 00", err); end
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_clr: got %b expected 00", gnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    req = 2'b00;
    step();
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 00", done); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [23:0] exp_data;
    rst = 1'b1; step(); rst = 1'b0;
    req_data = {24'h400a55, 24'h120301};
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (i % 2 == 0) ? 24'h120301 : 24'h400a55;
      if (i != 0) begin
        step();
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL cont_gap_gnt[%0d]: got %b expected 00", i, gnt); end
      end
      step();
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt); end
      n_chk++; if (eng_data !== exp_data) begin n_fail++; $display("FAIL cont_data[%0d]: got %h expected %h", i, eng_data, exp_data); end
      n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL cont_overlap[%0d]: got %b expected 0", i, eng_start); end
      step();
      n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL cont_start[%0d]: got %b expected 1", i, eng_start); end
      repeat (3) step();
      eng_done = 1'b1; eng_nack = 1'b0;
      step();
      eng_done = 1'b0;
      step(); step();
      n_chk++; if (done !== exp_gnt) begin n_fail++; $display("FAIL cont_done[%0d]: got %b expected %b", i, done, exp_gnt); end
      n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL cont_err[%0d]: got %b expected 00", i, err); end
      if (i == 7) req = 2'b00;
    end
  endtask

  task automatic test_nack_retry();
    int starts;
    // Two NACKs then ACK on requester 0
    step();
    req_data = {24'h400b66, 24'h120a0b}; req = 2'b01; starts = 0;
    step(); step();
    for (int a = 0; a < 3; a++) begin
      n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL nackA_start[%0d]: got %b expected 1", a, eng_start); end
      if (eng_start === 1'b1) starts++;
      repeat (4) step();
      eng_done = 1'b1; eng_nack = (a < 2);
      step();
      eng_done = 1'b0; eng_nack = 1'b0;
      if (a < 2) begin step(); step(); end
    end
    step();
    n_chk++; if ((done | err) !== 2'b00) begin n_fail++; $display("FAIL nackA_early: got %b expected 00", done | err); end
    step();
    n_chk++; if (done !== 2'b01) begin n_fail++; $display("FAIL nackA_done: got %b expected 01", done); end
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL nackA_err: got %b expected 00", err); end
    n_chk++; if (starts != 3) begin n_fail++; $display("FAIL nackA_starts: got %0d expected 3", starts); end
    req = 2'b00;
    // Three NACKs on requester 0; requester 1 arrives mid-transfer
    step();
    req = 2'b01;
    step(); step();
    req = 2'b11;
    for (int a = 0; a < 3; a++) begin
      n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL nackB_start[%0d]: got %b expected 1", a, eng_start); end
      n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL nackB_gnt[%0d]: got %b expected 01", a, gnt); end
      repeat (4) step();
      eng_done = 1'b1; eng_nack = 1'b1;
      step();
      eng_done = 1'b0; eng_nack = 1'b0;
      if (a < 2) begin step(); step(); end
    end
    step(); step();
    n_chk++; if (err !== 2'b01) begin n_fail++; $display("FAIL nackB_err: got %b expected 01", err); end
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL nackB_done: got %b expected 00", done); end
    req = 2'b10;
    step(); step();
    n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL nackB_next_gnt: got %b expected 10", gnt); end
    n_chk++; if (eng_data !== 24'h400b66) begin n_fail++; $display("FAIL nackB_next_data: got %h expected 400b66", eng_data); end
    step();
    repeat (3) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step(); step();
    n_chk++; if (done !== 2'b10) begin n_fail++; $display("FAIL nackB_next_done: got %b expected 10", done); end
    req = 2'b00;
  endtask

  task automatic test_stale_done();
    int bad;
    step();
    req_data[23:0] = 24'h120c0d; req = 2'b01; bad = 0;
    step(); step();
    repeat (3) step();
    eng_done = 1'b1; eng_nack = 1'b0;
    step();
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL stale_start_drop: got %b expected 0", eng_start); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++; if ((eng_start !== 1'b0) || (done !== 2'b00)) begin n_fail++; $display("FAIL stale_hold[%0d]: start %b done %b expected 0/00", i, eng_start, done); end
    end
    eng_done = 1'b0;
    step(); step();
    n_chk++; if (done !== 2'b01) begin n_fail++; $display("FAIL stale_done: got %b expected 01", done); end
    req = 2'b00;
    step();
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL stale_done_once: got %b expected 00", done); end
  endtask

  task automatic test_reset_mid();
    step();
    req_data = {24'h400e0f, 24'h121011}; req = 2'b10;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 00", gnt); end
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b expected 0", eng_start); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_chk++; if ((done | err) !== 2'b00) begin n_fail++; $display("FAIL rstmid_resp: got %b expected 00", done | err); end
    rst = 1'b0; req = 2'b11;
    step();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_ptr_gnt: got %b expected 01", gnt); end
    step();
    n_chk++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_start2: got %b expected 1", eng_start); end
    step(); step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step(); step();
    n_chk++; if (done !== 2'b01) begin n_fail++; $display("FAIL rstmid_done: got %b expected 01", done); end
    req = 2'b00;
    step(); step();
  endtask

  task automatic test_timeout();
    step();
    t_req_data[23:0] = 24'h4001ff; t_req = 2'b01;
    step();
    n_chk++; if (t_gnt !== 2'b01) begin n_fail++; $display("FAIL tmo_gnt: got %b expected 01", t_gnt); end
    step();
    repeat (99) step();
    n_chk++; if (t_eng_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start_held: got %b expected 1", t_eng_start); end
    step();
    n_chk++; if (t_eng_start !== 1'b0) begin n_fail++; $display("FAIL tmo_start_drop: got %b expected 0", t_eng_start); end
    n_chk++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL tmo_err_early: got %b expected 00", t_err); end
    step();
    n_chk++; if (t_err !== 2'b01) begin n_fail++; $display("FAIL tmo_err: got %b expected 01", t_err); end
    n_chk++; if (t_done !== 2'b00) begin n_fail++; $display("FAIL tmo_done: got %b expected 00", t_done); end
    n_chk++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b expected 0", t_busy); end
    t_req = 2'b00;
    step();
    n_chk++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL tmo_err_pulse: got %b expected 00", t_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_nack_retry();
    test_stale_done();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares one byte-oriented I2C write engine (24-bit {dev_addr, reg_addr, data} frames, start/tr_end handshake) between several requesters. Typical requesters are the ES8156 DAC init sequencer, the ADC codec init sequencer and run-time volume/mute writers. Arbitration is round-robin. The block also handles per-frame NACK retry and a watchdog timeout, and returns a one-cycle done or err pulse to the requester that owns the transaction. It sits between the codec config sequencers and the I2C engine, in the clk_12M domain.

## Interface
- NUM_REQ, 2: number of requesters (1..8).
- MAX_RETRY, 2: extra attempts after a NACK before reporting err (0..7).
- TIMEOUT_CYC, 60000: clk_12M cycles allowed per attempt before abort (≥16).
- clk_12M  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until done/err.
- req_data  in  NUM_REQ*24  frame of requester i at bits [24i+23:24i]; stable while req is high.
- gnt  out  NUM_REQ  one-hot owner of the engine; zero when idle.
- done  out  NUM_REQ  one-cycle pulse: frame ACKed.
- err  out  NUM_REQ  one-cycle pulse: retries exhausted or timeout.
- busy  out  1  high whenever the state is not IDLE.
- eng_start  out  1  engine start level; held until eng_done is seen.
- eng_data  out  24  frame to the engine; stable while eng_start is high.
- eng_done  in  1  engine transfer-end level (tr_end), already in the clk_12M domain.
- eng_nack  in  1  NACK flag; valid when eng_done is high.

## Operation
- States are IDLE, START, WAIT_DONE, WAIT_REL and RESP.
- IDLE
  - If any req is high, the rr_arbiter picks the first requester at or after rr_ptr (searching upward, wrapping at NUM_REQ).
  - The winner's frame is latched into eng_data, gnt is set to the winner, retry_cnt clears and the state moves to START.
- START
  - eng_start is set to 1, the timeout counter clears, and the state moves to WAIT_DONE.
- WAIT_DONE
  - If eng_done is high, eng_start is cleared and the NACK result is recorded, then the state moves to WAIT_REL.
  - If instead the counter reaches TIMEOUT_CYC-1, eng_start is cleared, a timeout is recorded and the state moves to RESP.
- WAIT_REL
  - The block waits for eng_done to go low, with the timeout counter still running.
  - If eng_done is low, the last attempt was a NACK and retry_cnt < MAX_RETRY, retry_cnt increments and the state returns to START. eng_data is reused unchanged.
  - If eng_done is low and the retry condition does not hold, the state moves to RESP.
  - A timeout in WAIT_REL also moves to RESP as err.
- RESP
  - Exactly one of done/err pulses for the owner: done on ACK; err on timeout or on a NACK after MAX_RETRY retries.
  - gnt clears in the same cycle, rr_ptr becomes owner+1 (mod NUM_REQ), and the state moves to IDLE.
- Requesters must drop req on the edge that samples done/err. A requester that keeps req high is re-queued behind the others; it is never re-granted back to back while another req is pending.
- req arriving mid-transaction waits; it does not preempt. A requester dropping req while granted is ignored: the frame completes and the response is still pulsed.
- Reset values: gnt=0, done=0, err=0, busy=0, eng_start=0, eng_data=0, rr_ptr=0, state=IDLE.
- Reset mid-transfer drops eng_start in the next cycle. The engine is expected to be reset by the same rst.
- Counter widths: timeout counter $clog2(TIMEOUT_CYC); retry_cnt 3 bits.

## Timing
- req rises in cycle N (state IDLE):
  - gnt and eng_data are valid in N+1.
  - eng_start is high in N+2.
- eng_done is high in cycle M: eng_start is low in M+1.
- eng_done falls in cycle K: for an ACK frame, done pulses in K+2.
- Minimum arbiter overhead is 4 cycles per frame plus engine time.
- Each retry adds 2 cycles plus engine time.
- Back-to-back grants: the earliest next eng_start is 3 cycles after the done pulse.
- Simultaneous req in IDLE: the lowest index at or after rr_ptr wins.
- eng_done already high at START (stale level): WAIT_DONE accepts it immediately. The engine must deassert tr_end before a new start.

## Structure
- i2c_arb_pkg holds:
  - the state enum;
  - FRAME_W=24;
  - codec device-address constants (ES8156 8'h12, ADC address);
  - a frame-pack function {dev, reg, data}.
- Sub-module rr_arbiter (parameter NUM_REQ) is combinational: inputs req and rr_ptr, outputs one-hot pick and pick_idx.
- The state machine, counters and response pulses live in i2c_cmd_arbiter.

## Test plan
- Single request: req[0] with frame 24'h120205, engine ACKs after 200 cycles → eng_data=24'h120205, eng_start high in N+2, done[0] is a single pulse, err=0, busy low afterward.
- Contention: req[0] and req[1] rise together with rr_ptr=0 → grant order 0, 1, 0, 1 over four frames per requester, and no eng_start overlap.
- NACK retry, MAX_RETRY=2:
  - Engine NACKs twice, then ACKs → 3 eng_start pulses and done (no err).
  - Engine NACKs three times → 3 attempts, then err, and the next requester is granted.
- Timeout: TIMEOUT_CYC=100 and eng_done never rises → eng_start falls at cycle 100 of WAIT_DONE, err pulses for the owner, and the state returns to IDLE.
- Reset mid-transfer: assert rst during WAIT_DONE → next cycle gnt=0, eng_start=0, busy=0, no done/err. A later request proceeds normally with rr_ptr=0.
- Stale eng_done: hold eng_done high for 10 cycles after completion → no new eng_start until it falls, and exactly one done pulse.
